shift_seq_ctrl: RTL and testbench
=================================

// Module: shift_seq_ctrl
// PURPOSE
//  Sequencer for a WIDTH-bit serial shift chain built from d_ff stages.
//  - Accepts a parallel word through a valid/ready handshake.
//  - Shifts the word out serially for exactly WIDTH clocks, and captures WIDTH serial input bits into a parallel word.
//  - Presents the captured word through a second valid/ready handshake.
//  - Drives shift_en to gate the external chain, so serial-in/serial-out and serial-in/parallel-out registers step in lock-step with it.
// PARAMETERS
//  WIDTH      4   bits per frame; legal range >= 2
//  CNT_W      3   bit-counter width; must satisfy 2**CNT_W > WIDTH
//  LSB_FIRST  0   0: MSB shifted out/in first; 1: LSB first
// PORTS
//  Clock        in   1      rising-edge clock
//  Resetn       in   1      asynchronous active-low reset
//  start_valid  in   1      tx_data valid, request a frame
//  start_ready  out  1      controller can accept a frame (IDLE only)
//  tx_data      in   WIDTH  parallel word to serialise
//  abort        in   1      synchronous frame cancel
//  sout         out  1      serial data to chain input
//  sin          in   1      serial data from chain output / line
//  shift_en     out  1      high for each shift cycle of the frame
//  busy         out  1      high in SHIFT or HOLD
//  rx_data      out  WIDTH  captured parallel word
//  rx_valid     out  1      rx_data valid
//  rx_ready     in   1      consumer accepts rx_data
// BEHAVIOUR
//  Reset (Resetn=0, async): state=IDLE, tx_sh=0, rx_sh=0, rx_data=0, bit_cnt=0.
//    Outputs during and after reset: start_ready=1, rx_valid=0, shift_en=0, sout=0, busy=0.
//  States: IDLE, SHIFT, HOLD. start_ready, shift_en, busy and rx_valid decode from state only.
//  IDLE: start_ready=1.
//    - On start_valid&&start_ready at edge k: tx_sh<=tx_data, bit_cnt<=0, go to SHIFT.
//  SHIFT: shift_en=1, busy=1.
//    - sout=tx_sh[WIDTH-1] (MSB first) or tx_sh[0] (LSB first); combinational from tx_sh.
//    - Each edge: tx_sh shifts toward sout, zero-filled.
//    - Each edge: rx_sh<={rx_sh[WIDTH-2:0],sin} (MSB first) or {sin,rx_sh[WIDTH-1:1]} (LSB first).
//    - Each edge: bit_cnt++.
//    - On the edge where bit_cnt==WIDTH-1: go to HOLD and latch the final rx_sh value (including this sin bit) into rx_data.
//  Latency: shift_en is high for exactly cycles k+1..k+WIDTH; rx_valid rises in cycle k+WIDTH+1.
//  HOLD: rx_valid=1, busy=1, shift_en=0, sout=0. rx_data stays stable.
//    - On rx_valid&&rx_ready: go to IDLE.
//    - rx_ready may be high already on entry; the minimum HOLD time is 1 cycle.
//  No frame overlap: a new frame can be accepted only in IDLE. Frame period >= WIDTH+2 cycles.
//  abort (sync) in any state: next state is IDLE.
//    - In SHIFT: the frame is truncated; rx_data is not updated and rx_valid never pulses.
//    - In HOLD: rx_valid drops the next cycle; rx_data keeps its last value.
//    - In IDLE with start_valid=1: abort wins; nothing is loaded and no handshake completes.
//      start_ready stays 1 that cycle, since it decodes from state, but the frame is dropped.
//  Resetn asserted mid-frame: immediate return to reset values. No partial rx_valid.
//  start_valid/tx_data are ignored outside IDLE. tx_data is sampled only at the accept edge.
//  bit_cnt never exceeds WIDTH-1. No wrap occurs because the state leaves SHIFT first.
// TESTING
//  1 Reset: Resetn=0 mid-SHIFT -> start_ready=1, shift_en=0, rx_valid=0, rx_data=0 immediately.
//  2 Loopback (sin=sout), WIDTH=4, LSB_FIRST=0, tx_data=4'b1011 ->
//    sout=1,0,1,1 over 4 shift_en cycles; rx_data=4'b1011; rx_valid at cycle k+5.
//  3 LSB_FIRST=1, tx_data=4'b0001, loopback -> sout=1,0,0,0; rx_data=4'b0001.
//  4 Backpressure: rx_ready=0 for 10 cycles in HOLD -> rx_valid and rx_data held;
//    start_valid ignored; IDLE 1 cycle after rx_ready=1.
//  5 abort asserted in the 2nd SHIFT cycle -> IDLE next cycle; rx_valid never asserts;
//    the previous rx_data value is unchanged.
//  6 Back-to-back: start_valid held high with rx_ready=1 -> frames accepted every WIDTH+2 cycles;
//    shift_en duty is exactly WIDTH cycles per frame.

Source files
------------

// File: rtl/shift_seq_ctrl_if.sv
// Handshake and serial-chain signals of the shift sequencer.
// master: frame producer / consumer / chain side; slave: the controller.
interface shift_seq_ctrl_if #(
   parameter int WIDTH = 4
);
   logic             start_valid;
   logic             start_ready;
   logic [WIDTH-1:0] tx_data;
   logic             abort;
   logic             sout;
   logic             sin;
   logic             shift_en;
   logic             busy;
   logic [WIDTH-1:0] rx_data;
   logic             rx_valid;
   logic             rx_ready;

   modport master (
      output start_valid, tx_data, abort, sin, rx_ready,
      input  start_ready, sout, shift_en, busy, rx_data, rx_valid
   );

   modport slave (
      input  start_valid, tx_data, abort, sin, rx_ready,
      output start_ready, sout, shift_en, busy, rx_data, rx_valid
   );
endinterface

// File: rtl/shift_seq_ctrl.sv
// Serial shift-chain sequencer: loads a word, shifts it out for WIDTH clocks
// while capturing WIDTH input bits, then presents the captured word.
module shift_seq_ctrl #(
   parameter int WIDTH     = 4,
   parameter int CNT_W     = 3,
   parameter bit LSB_FIRST = 1'b0
) (
   input logic             Clock,
   input logic             Resetn,
   shift_seq_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] tx_sh, rx_sh, rx_q;
   logic [WIDTH-1:0] tx_shifted, rx_nxt;
   logic [CNT_W-1:0] bit_cnt;
   logic             last_bit;

   assign tx_shifted = LSB_FIRST ? {1'b0, tx_sh[WIDTH-1:1]} : {tx_sh[WIDTH-2:0], 1'b0};
   assign rx_nxt     = LSB_FIRST ? {bus.sin, rx_sh[WIDTH-1:1]} : {rx_sh[WIDTH-2:0], bus.sin};
   assign last_bit   = (bit_cnt == CNT_W'(WIDTH - 1));

   always_comb begin
      state_nxt       = state;
      bus.start_ready = 1'b0;
      bus.shift_en    = 1'b0;
      bus.busy        = 1'b0;
      bus.rx_valid    = 1'b0;
      bus.sout        = 1'b0;
      case (state)
         IDLE: begin
            bus.start_ready = 1'b1;
            if (bus.abort)            state_nxt = IDLE;
            else if (bus.start_valid) state_nxt = SHIFT;
         end
         SHIFT: begin
            bus.shift_en = 1'b1;
            bus.busy     = 1'b1;
            bus.sout     = LSB_FIRST ? tx_sh[0] : tx_sh[WIDTH-1];
            if (bus.abort)     state_nxt = IDLE;
            else if (last_bit) state_nxt = HOLD;
         end
         HOLD: begin
            bus.rx_valid = 1'b1;
            bus.busy     = 1'b1;
            if (bus.abort || bus.rx_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   // Datapath only advances on non-aborted cycles, so a cancelled frame
   // never disturbs the previously presented rx word.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         tx_sh   <= '0;
         rx_sh   <= '0;
         rx_q    <= '0;
         bit_cnt <= '0;
      end else if (!bus.abort) begin
         if (state == IDLE && bus.start_valid) begin
            tx_sh   <= bus.tx_data;
            bit_cnt <= '0;
         end else if (state == SHIFT) begin
            tx_sh   <= tx_shifted;
            rx_sh   <= rx_nxt;
            bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
            if (last_bit) rx_q <= rx_nxt;
         end
      end
   end

   assign bus.rx_data = rx_q;
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: MSB-first and LSB-first instances driven in parallel,
// table vectors, hand sequences for reset/abort/back-to-back, then random frames.
module tb_shift_seq_ctrl;
   localparam int W = 4;

   logic Clock = 1'b0;
   logic Resetn = 1'b0;
   always #5 Clock = ~Clock;

   shift_seq_ctrl_if #(.WIDTH(W)) if_m ();
   shift_seq_ctrl_if #(.WIDTH(W)) if_l ();

   shift_seq_ctrl #(.WIDTH(W), .CNT_W(3), .LSB_FIRST(1'b0)) dut_m (
      .Clock(Clock), .Resetn(Resetn), .bus(if_m.slave));
   shift_seq_ctrl #(.WIDTH(W), .CNT_W(3), .LSB_FIRST(1'b1)) dut_l (
      .Clock(Clock), .Resetn(Resetn), .bus(if_l.slave));

   logic         sv = 1'b0, ab = 1'b0, rr = 1'b0, loop = 1'b0, sin_drv = 1'b0;
   logic [W-1:0] txd = '0;

   assign if_m.start_valid = sv;
   assign if_l.start_valid = sv;
   assign if_m.tx_data     = txd;
   assign if_l.tx_data     = txd;
   assign if_m.abort       = ab;
   assign if_l.abort       = ab;
   assign if_m.rx_ready    = rr;
   assign if_l.rx_ready    = rr;
   assign if_m.sin         = loop ? if_m.sout : sin_drv;
   assign if_l.sin         = loop ? if_l.sout : sin_drv;

   int           nvec = 0, nerr = 0;
   logic [W-1:0] last_m = '0, last_l = '0;

   typedef struct {
      logic [W-1:0] tx;
      logic [W-1:0] seq;   // bit i = sin value in shift cycle i
      bit           lp;
      int           hw;
      int           abort_at; // -1 none, 0..W-1 shift cycle, W = first HOLD cycle
      logic [W-1:0] em;
      logic [W-1:0] el;
   } vec_t;

   task automatic chk_bit(input string nm, input logic act, input logic exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0b expected %0b @%0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_word(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %b expected %b @%0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_int(input string nm, input int act, input int exp);
      nvec++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d @%0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_st(input string nm, input logic sr, input logic se, input logic bz, input logic rv);
      chk_bit({nm, " start_ready m"}, if_m.start_ready, sr);
      chk_bit({nm, " start_ready l"}, if_l.start_ready, sr);
      chk_bit({nm, " shift_en m"},    if_m.shift_en,    se);
      chk_bit({nm, " shift_en l"},    if_l.shift_en,    se);
      chk_bit({nm, " busy m"},        if_m.busy,        bz);
      chk_bit({nm, " busy l"},        if_l.busy,        bz);
      chk_bit({nm, " rx_valid m"},    if_m.rx_valid,    rv);
      chk_bit({nm, " rx_valid l"},    if_l.rx_valid,    rv);
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic smp();
      @(negedge Clock);
   endtask

   // Serial order to parallel word: MSB-first puts the first bit at the top.
   function automatic logic [W-1:0] model_rx(input logic [W-1:0] seq, input bit lsb);
      logic [W-1:0] r = '0;
      for (int i = 0; i < W; i++) begin
         if (lsb) r[i] = seq[i];
         else     r[W-1-i] = seq[i];
      end
      return r;
   endfunction

   // Called at #1 after a posedge with both DUTs in IDLE; returns likewise.
   task automatic do_frame(input string nm, input logic [W-1:0] tx, input logic [W-1:0] seq,
                           input bit lp, input int hw, input int abort_at,
                           input logic [W-1:0] em, input logic [W-1:0] el);
      sv = 1'b1; txd = tx; loop = lp; ab = 1'b0; rr = 1'b0;
      smp();
      chk_bit({nm, " accept ready m"}, if_m.start_ready, 1'b1);
      chk_bit({nm, " accept ready l"}, if_l.start_ready, 1'b1);
      tick();
      sv = 1'b0; txd = ~tx;
      for (int i = 0; i < W; i++) begin
         sin_drv = seq[i];
         ab = (abort_at == i);
         smp();
         chk_st({nm, " shift"}, 1'b0, 1'b1, 1'b1, 1'b0);
         chk_bit({nm, " sout m"}, if_m.sout, tx[W-1-i]);
         chk_bit({nm, " sout l"}, if_l.sout, tx[i]);
         tick();
         ab = 1'b0;
         if (abort_at == i) begin
            smp();
            chk_st({nm, " post-abort"}, 1'b1, 1'b0, 1'b0, 1'b0);
            chk_word({nm, " rx_data kept m"}, if_m.rx_data, last_m);
            chk_word({nm, " rx_data kept l"}, if_l.rx_data, last_l);
            tick();
            smp();
            chk_st({nm, " idle after abort"}, 1'b1, 1'b0, 1'b0, 1'b0);
            tick();
            return;
         end
      end
      // first HOLD cycle
      rr = (hw == 0) && (abort_at != W);
      sv = (hw > 0);
      txd = W'($urandom);
      ab = (abort_at == W);
      smp();
      chk_st({nm, " hold"}, 1'b0, 1'b0, 1'b1, 1'b1);
      chk_bit({nm, " hold sout m"}, if_m.sout, 1'b0);
      chk_bit({nm, " hold sout l"}, if_l.sout, 1'b0);
      chk_word({nm, " rx_data m"}, if_m.rx_data, em);
      chk_word({nm, " rx_data l"}, if_l.rx_data, el);
      last_m = em; last_l = el;
      tick();
      if (abort_at == W) begin
         ab = 1'b0; sv = 1'b0;
         smp();
         chk_st({nm, " hold abort"}, 1'b1, 1'b0, 1'b0, 1'b0);
         chk_word({nm, " rx_data after abort m"}, if_m.rx_data, em);
         chk_word({nm, " rx_data after abort l"}, if_l.rx_data, el);
         tick();
         return;
      end
      for (int j = 1; j <= hw; j++) begin
         if (j == hw) begin rr = 1'b1; sv = 1'b0; end
         smp();
         chk_st({nm, " backpressure"}, 1'b0, 1'b0, 1'b1, 1'b1);
         chk_word({nm, " held rx m"}, if_m.rx_data, em);
         chk_word({nm, " held rx l"}, if_l.rx_data, el);
         tick();
      end
      rr = 1'b0;
      smp();
      chk_st({nm, " back to idle"}, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
   endtask

   vec_t vecs[6];

   initial begin
      vecs[0] = '{4'b1011, 4'b0000, 1'b1, 0,  -1, 4'b1011, 4'b1011};
      vecs[1] = '{4'b0001, 4'b0000, 1'b1, 0,  -1, 4'b0001, 4'b0001};
      vecs[2] = '{4'b0110, 4'b0011, 1'b0, 2,  -1, 4'b1100, 4'b0011};
      vecs[3] = '{4'b1111, 4'b1000, 1'b0, 10, -1, 4'b0001, 4'b1000};
      vecs[4] = '{4'b1010, 4'b0000, 1'b1, 0,   1, 4'b0000, 4'b0000};
      vecs[5] = '{4'b0101, 4'b0000, 1'b1, 1,   W, 4'b0101, 4'b0101};

      // reset state
      #2;
      chk_st("reset", 1'b1, 1'b0, 1'b0, 1'b0);
      chk_word("reset rx_data m", if_m.rx_data, '0);
      chk_bit("reset sout m", if_m.sout, 1'b0);
      chk_bit("reset sout l", if_l.sout, 1'b0);
      smp();
      Resetn = 1'b1;
      tick();

      foreach (vecs[v])
         do_frame($sformatf("vec%0d", v), vecs[v].tx, vecs[v].seq, vecs[v].lp,
                  vecs[v].hw, vecs[v].abort_at, vecs[v].em, vecs[v].el);

      // abort beats start_valid in IDLE
      sv = 1'b1; ab = 1'b1; txd = 4'b1110;
      smp();
      chk_bit("idle abort ready", if_m.start_ready, 1'b1);
      tick();
      sv = 1'b0; ab = 1'b0;
      smp();
      chk_st("idle abort no frame", 1'b1, 1'b0, 1'b0, 1'b0);
      chk_word("idle abort rx m", if_m.rx_data, last_m);
      tick();

      // back-to-back frames with rx_ready held
      begin
         int acc = 0, se_m = 0, se_l = 0, prev = -1;
         sv = 1'b1; rr = 1'b1; loop = 1'b1; txd = 4'b1101;
         for (int c = 0; c < 3 * (W + 2); c++) begin
            smp();
            if (if_m.start_ready) begin
               acc++;
               if (prev >= 0) chk_int("b2b spacing", c - prev, W + 2);
               prev = c;
            end
            se_m += int'(if_m.shift_en);
            se_l += int'(if_l.shift_en);
            if (if_m.rx_valid) begin
               chk_word("b2b rx m", if_m.rx_data, 4'b1101);
               chk_word("b2b rx l", if_l.rx_data, 4'b1101);
            end
            tick();
         end
         sv = 1'b0; rr = 1'b0;
         chk_int("b2b frames", acc, 3);
         chk_int("b2b shift_en m", se_m, 3 * W);
         chk_int("b2b shift_en l", se_l, 3 * W);
         last_m = 4'b1101; last_l = 4'b1101;
         smp();
         chk_st("b2b idle", 1'b1, 1'b0, 1'b0, 1'b0);
         tick();
      end

      // reset asserted mid-SHIFT
      sv = 1'b1; txd = 4'b1111; loop = 1'b1;
      tick();
      sv = 1'b0;
      tick();
      Resetn = 1'b0;
      #1;
      chk_st("mid reset", 1'b1, 1'b0, 1'b0, 1'b0);
      chk_word("mid reset rx m", if_m.rx_data, '0);
      chk_word("mid reset rx l", if_l.rx_data, '0);
      last_m = '0; last_l = '0;
      smp();
      Resetn = 1'b1;
      tick();

      // random frames against the model
      for (int n = 0; n < 24; n++) begin
         logic [W-1:0] tx, seq, sm, sl;
         bit lp;
         int hw, abt;
         tx  = W'($urandom);
         seq = W'($urandom);
         lp  = 1'($urandom_range(0, 1));
         hw  = $urandom_range(0, 3);
         abt = ($urandom_range(0, 5) == 0) ? $urandom_range(0, W) : -1;
         for (int i = 0; i < W; i++) begin
            sm[i] = lp ? tx[W-1-i] : seq[i];
            sl[i] = lp ? tx[i]     : seq[i];
         end
         do_frame($sformatf("rnd%0d", n), tx, seq, lp, hw, abt,
                  model_rx(sm, 1'b0), model_rx(sl, 1'b1));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end
endmodule
